// File: rtl/pulse_pkg.sv
// Shared constants and state encoding for the pulse measurement / pulse source pair.
package pulse_pkg;

    typedef enum logic [1:0] {
        P_IDLE      = 2'd0,
        P_WAIT_RISE = 2'd1,
        P_MEAS_HIGH = 2'd2,
        P_DONE      = 2'd3
    } pulse_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT = 32'd4000000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a registered copy for single-cycle rise/fall detection.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= i_d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign o_sync = sync;
    assign o_rise = sync & ~prev;
    assign o_fall = ~sync & prev;

endmodule

// File: rtl/pulse_meas.sv
// Armed one-shot pulse receiver: measures arm-to-rise delay and high width in clock cycles.
module pulse_meas
    import pulse_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pulse,
    input  logic        i_arm,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_posedge_time,
    output logic [31:0] o_width
);

    pulse_state_t state;
    logic [31:0]  pos_cnt;
    logic [31:0]  wid_cnt;
    logic         pulse_sync;
    logic         rise_det;
    logic         fall_det;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pulse),
        .o_sync  (pulse_sync),
        .o_rise  (rise_det),
        .o_fall  (fall_det)
    );

    // Both edges carry the same detect latency, so the width needs no correction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= P_IDLE;
            pos_cnt        <= '0;
            wid_cnt        <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_timeout      <= 1'b0;
            o_posedge_time <= '0;
            o_width        <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                P_IDLE: begin
                    if (i_arm) begin
                        pos_cnt <= '0;
                        wid_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= P_WAIT_RISE;
                    end
                end
                P_WAIT_RISE: begin
                    if (rise_det) begin
                        wid_cnt <= 32'd1;
                        state   <= P_MEAS_HIGH;
                    end else if (pos_cnt == TIMEOUT) begin
                        o_done         <= 1'b1;
                        o_timeout      <= 1'b1;
                        o_posedge_time <= pos_cnt;
                        o_width        <= '0;
                        state          <= P_DONE;
                    end else begin
                        pos_cnt <= pos_cnt + 32'd1;
                    end
                end
                P_MEAS_HIGH: begin
                    if (fall_det) begin
                        o_done         <= 1'b1;
                        o_timeout      <= 1'b0;
                        o_posedge_time <= pos_cnt;
                        o_width        <= wid_cnt;
                        state          <= P_DONE;
                    end else if (wid_cnt == TIMEOUT) begin
                        o_done         <= 1'b1;
                        o_timeout      <= 1'b1;
                        o_posedge_time <= pos_cnt;
                        o_width        <= wid_cnt;
                        state          <= P_DONE;
                    end else begin
                        wid_cnt <= wid_cnt + 32'd1;
                    end
                end
                P_DONE: begin
                    o_busy <= 1'b0;
                    state  <= P_IDLE;
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    logic unused_sync;
    assign unused_sync = pulse_sync;

endmodule

// File: tb/tb_pulse_meas.sv
// Scoreboard bench for pulse_meas: one instance at default TIMEOUT, one at TIMEOUT=20.
module tb_pulse_meas;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pulse = 1'b0;
    logic        arm_a   = 1'b0;
    logic        arm_t   = 1'b0;

    logic        busy_a, done_a, to_a;
    logic [31:0] pos_a, wid_a;
    logic        busy_t, done_t, to_t;
    logic [31:0] pos_t, wid_t;

    typedef struct {
        logic [31:0] pos;
        logic [31:0] wid;
        logic        to;
    } res_t;

    res_t q_a[$];
    res_t q_t[$];

    int passed = 0;
    int total  = 0;
    int edge_n = 0;
    int base   = 0;

    pulse_meas #(.TIMEOUT(32'd4000000)) dut_a (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pulse        (i_pulse),
        .i_arm          (arm_a),
        .o_busy         (busy_a),
        .o_done         (done_a),
        .o_timeout      (to_a),
        .o_posedge_time (pos_a),
        .o_width        (wid_a)
    );

    pulse_meas #(.TIMEOUT(32'd20)) dut_t (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pulse        (i_pulse),
        .i_arm          (arm_t),
        .o_busy         (busy_t),
        .o_done         (done_t),
        .o_timeout      (to_t),
        .o_posedge_time (pos_t),
        .o_width        (wid_t)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edge_n <= edge_n + 1;

    always @(negedge i_clk) begin : mon_a
        res_t e;
        if (i_rst_n && done_a) begin
            total++;
            if (q_a.size() == 0) begin
                $display("FAIL result_a unexpected done: pos=%0d wid=%0d to=%0b, required no strobe",
                         pos_a, wid_a, to_a);
            end else begin
                e = q_a.pop_front();
                if (pos_a !== e.pos || wid_a !== e.wid || to_a !== e.to)
                    $display("FAIL result_a: got pos=%0d wid=%0d to=%0b, required pos=%0d wid=%0d to=%0b",
                             pos_a, wid_a, to_a, e.pos, e.wid, e.to);
                else
                    passed++;
            end
        end
    end

    always @(negedge i_clk) begin : mon_t
        res_t e;
        if (i_rst_n && done_t) begin
            total++;
            if (q_t.size() == 0) begin
                $display("FAIL result_t unexpected done: pos=%0d wid=%0d to=%0b, required no strobe",
                         pos_t, wid_t, to_t);
            end else begin
                e = q_t.pop_front();
                if (pos_t !== e.pos || wid_t !== e.wid || to_t !== e.to)
                    $display("FAIL result_t: got pos=%0d wid=%0d to=%0b, required pos=%0d wid=%0d to=%0b",
                             pos_t, wid_t, to_t, e.pos, e.wid, e.to);
                else
                    passed++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Called at a negedge; the following posedge is relative edge 0.
    task automatic arm(input bit which);
        if (which) arm_t = 1'b1;
        else       arm_a = 1'b1;
        @(negedge i_clk);
        arm_a = 1'b0;
        arm_t = 1'b0;
        base  = edge_n;
    endtask

    // Returns at the negedge immediately before relative edge e.
    task automatic before_edge(input int e);
        while (edge_n - base < e - 1) @(negedge i_clk);
    endtask

    task automatic wait_done(input bit which, input int limit);
        int n = 0;
        while (!(which ? done_t : done_a) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= limit) begin
            total++;
            $display("FAIL wait_done(%0d): no o_done within %0d cycles", which, limit);
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        idle(3);
        total++;
        if ({busy_a, done_a, to_a, pos_a, wid_a} !== '0)
            $display("FAIL reset_a: got busy=%0b done=%0b to=%0b pos=%0d wid=%0d, required all 0",
                     busy_a, done_a, to_a, pos_a, wid_a);
        else passed++;
        total++;
        if ({busy_t, done_t, to_t, pos_t, wid_t} !== '0)
            $display("FAIL reset_t: got busy=%0b done=%0b to=%0b pos=%0d wid=%0d, required all 0",
                     busy_t, done_t, to_t, pos_t, wid_t);
        else passed++;
        i_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        q_a.push_back('{32'd101, 32'd50, 1'b0});
        arm(1'b0);
        total++;
        if (busy_a !== 1'b1) $display("FAIL busy_rise: got %0b, required 1", busy_a);
        else passed++;
        before_edge(100); i_pulse = 1'b1;
        before_edge(150); i_pulse = 1'b0;
        before_edge(152);
        total++;
        if (done_a !== 1'b0) $display("FAIL done_early: got %0b, required 0", done_a);
        else passed++;
        before_edge(153);
        total++;
        if (done_a !== 1'b1 || busy_a !== 1'b1)
            $display("FAIL done_timing: got done=%0b busy=%0b, required done=1 busy=1", done_a, busy_a);
        else passed++;
        @(negedge i_clk);
        total++;
        if (done_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL done_fall: got done=%0b busy=%0b, required done=0 busy=0", done_a, busy_a);
        else passed++;
        idle(5);
    endtask

    task automatic test_wait_timeout;
        q_t.push_back('{32'd20, 32'd0, 1'b1});
        arm(1'b1);
        wait_done(1'b1, 100);
        idle(5);
    endtask

    task automatic test_high_timeout;
        q_t.push_back('{32'd6, 32'd20, 1'b1});
        arm(1'b1);
        before_edge(5); i_pulse = 1'b1;
        wait_done(1'b1, 100);
        @(negedge i_clk);
        i_pulse = 1'b0;
        idle(5);
    endtask

    task automatic test_high_at_arm;
        i_pulse = 1'b1;
        idle(5);
        q_a.push_back('{32'd31, 32'd1, 1'b0});
        arm(1'b0);
        before_edge(10); i_pulse = 1'b0;
        before_edge(30); i_pulse = 1'b1;
        before_edge(31); i_pulse = 1'b0;
        wait_done(1'b0, 60);
        idle(5);
    endtask

    task automatic test_arm_ignored;
        q_a.push_back('{32'd21, 32'd40, 1'b0});
        arm(1'b0);
        before_edge(20); i_pulse = 1'b1;
        before_edge(40); arm_a = 1'b1;
        before_edge(41); arm_a = 1'b0;
        before_edge(60); i_pulse = 1'b0;
        before_edge(63);
        total++;
        if (done_a !== 1'b1) $display("FAIL done_perturbed: got %0b, required 1", done_a);
        else passed++;
        arm_a = 1'b1;
        before_edge(64); arm_a = 1'b0;
        before_edge(66);
        total++;
        if (busy_a !== 1'b0) $display("FAIL arm_in_done: got busy=%0b, required 0", busy_a);
        else passed++;
        idle(30);
    endtask

    task automatic test_reset_mid;
        arm(1'b0);
        before_edge(5); i_pulse = 1'b1;
        before_edge(15);
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({busy_a, done_a, to_a, pos_a, wid_a} !== '0)
            $display("FAIL reset_mid: got busy=%0b done=%0b to=%0b pos=%0d wid=%0d, required all 0",
                     busy_a, done_a, to_a, pos_a, wid_a);
        else passed++;
        @(negedge i_clk);
        i_pulse = 1'b0;
        i_rst_n = 1'b1;
        idle(5);
        total++;
        if (busy_a !== 1'b0) $display("FAIL idle_after_reset: got busy=%0b, required 0", busy_a);
        else passed++;
        q_a.push_back('{32'd8, 32'd5, 1'b0});
        arm(1'b0);
        before_edge(7);  i_pulse = 1'b1;
        before_edge(12); i_pulse = 1'b0;
        wait_done(1'b0, 60);
        idle(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_timeout();
        test_high_timeout();
        test_high_at_arm();
        test_arm_ignored();
        test_reset_mid();
        total++;
        if (q_a.size() != 0 || q_t.size() != 0)
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q_a.size(), q_t.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
